// File: rtl/div.sv
// div: 32-bit radix-2 restoring divider, {remainder, quotient} result.
// Optional signed support is compiled in only when DIV_SIGNED_EN is defined;
// otherwise signed_div_i is ignored and every division is unsigned.
//
// state       | meaning
// ------------+---------------------------------------------------
// DIV_FREE    | idle, waiting for start_i; outputs held at zero
// DIV_BY_ZERO | zero divisor seen, zero result on next edge
// DIV_ON      | one restoring iteration per cycle, cnt 0..31; cnt 32 finalises
// DIV_END     | result valid, held until start_i drops
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_divisor;
  logic [63:0] r_result;
  logic        r_ready;

  logic [31:0] w_op1_mag;
  logic [31:0] w_op2_mag;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [32:0] w_shift;
  logic [33:0] w_trial;
  logic        w_borrow;

`ifdef DIV_SIGNED_EN
  logic r_sign1;
  logic r_sign2;

  // Magnitudes of the incoming operands; negative values only matter when signed.
  assign w_op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  // Quotient negative when signs differ; remainder follows the dividend's sign.
  // 0x80000000 / -1 wraps back to 0x80000000 naturally through this negation.
  assign w_quo_fix = (r_sign1 ^ r_sign2) ? (~r_quo + 32'd1) : r_quo;
  assign w_rem_fix = r_sign1 ? (~r_rem + 32'd1) : r_rem;
`else
  logic w_unused_sign;

  assign w_unused_sign = signed_div_i;
  assign w_op1_mag     = opdata1_i;
  assign w_op2_mag     = opdata2_i;
  assign w_quo_fix     = r_quo;
  assign w_rem_fix     = r_rem;
`endif

  // One restoring step: shift next dividend bit into the partial remainder and trial-subtract.
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_trial  = {1'b0, w_shift} - {2'b00, r_divisor};
  assign w_borrow = w_trial[33];

  assign result_o = r_result;
  assign ready_o  = r_ready;

  // Sequencing FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= 6'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_divisor <= 32'd0;
      r_result  <= 64'd0;
      r_ready   <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
`endif
    end else begin
      case (r_state)
        DIV_FREE: begin
          r_ready  <= 1'b0;
          r_result <= 64'd0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              r_state <= DIV_BY_ZERO;
            end else begin
              r_state   <= DIV_ON;
              r_cnt     <= 6'd0;
              r_rem     <= 32'd0;
              r_quo     <= w_op1_mag;
              r_divisor <= w_op2_mag;
`ifdef DIV_SIGNED_EN
              r_sign1   <= signed_div_i & opdata1_i[31];
              r_sign2   <= signed_div_i & opdata2_i[31];
`endif
            end
          end
        end
        DIV_BY_ZERO: begin
          r_result <= 64'd0;
          if (annul_i) begin
            r_state <= DIV_FREE;
            r_ready <= 1'b0;
          end else begin
            r_state <= DIV_END;
            r_ready <= 1'b1;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            r_state  <= DIV_FREE;
            r_ready  <= 1'b0;
            r_result <= 64'd0;
          end else if (!r_cnt[5]) begin
            r_rem <= w_borrow ? w_shift[31:0] : w_trial[31:0];
            r_quo <= {r_quo[30:0], ~w_borrow};
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_result <= {w_rem_fix, w_quo_fix};
            r_ready  <= 1'b1;
            r_state  <= DIV_END;
          end
        end
        default: begin
          if (!start_i) begin
            r_state  <= DIV_FREE;
            r_ready  <= 1'b0;
            r_result <= 64'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb_div: randomized and directed checks of div against an arithmetic reference.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_tests;
  int n_fail;

  div u_div (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint x, y, q, r;
    bit     se;
    se = s;
`ifndef DIV_SIGNED_EN
    se = 1'b0;
`endif
    if (b == 32'd0) return 64'd0;
    if (se) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge: issues the request, scrambles operands after capture,
  // checks latency, result, hold (with a harmless annul) and clear.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit s, input logic [63:0] exp);
    int n;
    bit seen;
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      n++;
      if (n == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
      end
      if (ready_o) seen = 1'b1;
    end
    chk({tag, "_lat"}, 64'(n), (b == 32'd0) ? 64'd2 : 64'd34);
    chk({tag, "_res"}, result_o, exp);
    annul_i = 1'b1;
    tick();
    chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
    chk({tag, "_hold_res"}, result_o, exp);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    chk({tag, "_clr_rdy"}, 64'(ready_o), 64'd0);
    chk({tag, "_clr_res"}, result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    bit          s;
    bit          rose;
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) tick();
    chk("rst_rdy", 64'(ready_o), 64'd0);
    chk("rst_res", result_o, 64'd0);
    rst = 1'b1;
    tick();

    do_div("u100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E);
`ifdef DIV_SIGNED_EN
    do_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
    do_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000);
`else
    do_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'h00000001_7FFFFFFC);
    do_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h80000000_00000000);
`endif
    do_div("zero", 32'h1234, 32'd0, 1'b0, 64'd0);

    // Annul at cnt=10, then an immediate new request.
    opdata1_i    = 32'hFFFFFFFF;
    opdata2_i    = 32'd3;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    rose         = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      if (ready_o) rose = 1'b1;
      tick();
    end
    annul_i = 1'b1;
    tick();
    if (ready_o) rose = 1'b1;
    chk("annul_rdy_never", 64'(rose), 64'd0);
    chk("annul_res", result_o, 64'd0);
    do_div("after_annul", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003);

    // Reset at cnt=20 mid-division.
    opdata1_i = 32'h12345678;
    opdata2_i = 32'h11;
    start_i   = 1'b1;
    tick();
    repeat (20) tick();
    rst = 1'b0;
    tick();
    chk("midrst_rdy", 64'(ready_o), 64'd0);
    chk("midrst_res", result_o, 64'd0);
    rst     = 1'b1;
    start_i = 1'b0;
    rose    = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready_o) rose = 1'b1;
    end
    chk("midrst_idle", 64'(rose), 64'd0);
    do_div("after_rst", 32'd1000, 32'd10, 1'b0, model(32'd1000, 32'd10, 1'b0));

    // Randomized operands, with zero and small divisors mixed in.
    for (int t = 0; t < 24; t++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1, 2: b = 32'($urandom_range(1, 17));
        3: b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      do_div($sformatf("rnd%0d", t), a, b, s, model(a, b, s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have reset synchronous and active-low, on one clock: `clk` and `rst` as below.
REQ-002 `clk`  input  1  Sole clock; all state updates on the rising edge.
REQ-003 `rst`  input  1  Synchronous, active-low reset; sampled on the rising edge of `clk`.
REQ-004 `signed_div_i`  input  1  1 = signed (`DIV`), 0 = unsigned (`DIVU`); sampled with `start_i`.
REQ-005 `opdata1_i`  input  32  Dividend; sampled with `start_i`.
REQ-006 `opdata2_i`  input  32  Divisor; sampled with `start_i`.
REQ-007 `start_i`  input  1  Division request from EX. Held high until `ready_o` is seen.
REQ-008 `annul_i`  input  1  Cancel request from EX (exception or flush).
REQ-009 `result_o`  output  64  Result as {remainder, quotient}, i.e. {HI, LO}.
REQ-010 `ready_o`  output  1  Result valid.

Function
REQ-011 FSM states: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`; 2-bit encoding; 6-bit iteration counter `cnt`.
REQ-012 `DivFree`, `start_i`=1, `annul_i`=0, `opdata2_i`=0 SHALL go to `DivByZero`.
REQ-013 `DivFree`, `start_i`=1, `annul_i`=0, `opdata2_i`≠0 SHALL do all of the following:
- go to `DivOn` with `cnt`=0;
- latch operand magnitudes (two's-complement negation of negative operands when signed);
- latch both operand sign bits.
REQ-014 `DivFree` with `start_i`=0, or with `annul_i`=1, SHALL stay in `DivFree` and hold `ready_o`=0 and `result_o`=0.
REQ-015 `DivByZero` SHALL go to `DivEnd` on the next edge with a 64-bit zero result.
REQ-016 `DivOn` with `annul_i`=0 and `cnt`<32 SHALL perform one radix-2 restoring iteration per cycle, then increment `cnt`.
- 65-bit shift of the {remainder, dividend} register.
- Trial subtract of the divisor (33-bit) from the upper part.
- Quotient bit is 1 if the subtraction does not borrow.
REQ-017 `DivOn` with `cnt`=32 SHALL register the final result, set `ready_o`=1 and go to `DivEnd`.
- Signed quotient is negated if the operand signs differ.
- Signed remainder takes the sign of the dividend.
REQ-018 `annul_i`=1 in `DivOn` or `DivByZero` SHALL return the FSM to `DivFree` on that edge, with `ready_o`=0 and `result_o`=0; `annul_i` in `DivEnd` has no effect.
REQ-019 Latency from the `start_i` sampling edge to `ready_o` high:
- nonzero divisor: exactly 34 edges;
- zero divisor: exactly 2 edges.
REQ-020 `DivEnd` SHALL hold `ready_o`=1 and `result_o` stable while `start_i`=1.
REQ-021 When `start_i`=0 is sampled in `DivEnd`, the block SHALL go to `DivFree` and clear `ready_o` and `result_o` on that edge.
REQ-022 `start_i` and operand changes outside `DivFree` SHALL be ignored; the operands are captured once only.
REQ-023 Signed overflow case 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-024 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 `rst`=0 at a rising edge SHALL force all of the following, taking priority over every other input, including mid-division:
- FSM to `DivFree`;
- `cnt` to 0;
- `ready_o` to 0;
- `result_o` to 0;
- internal operand and remainder registers to 0.
REQ-026 The first `start_i` sampled after `rst` returns high SHALL be accepted normally.

Configuration
REQ-027 With macro `DIV_SIGNED_EN` defined, `signed_div_i` SHALL be honoured per REQ-013 and REQ-017.
REQ-028 Without `DIV_SIGNED_EN`, `signed_div_i` SHALL be ignored: no sign-fix logic is compiled in and all divisions are unsigned.

Verification
REQ-029 Unsigned, `opdata1_i`=100, `opdata2_i`=7, `start_i` held → `ready_o` 34 edges later; `result_o`=0x00000002_0000000E.
REQ-030 Signed (`DIV_SIGNED_EN`), `opdata1_i`=0xFFFFFFF9 (-7), `opdata2_i`=2 → `result_o`=0xFFFFFFFF_FFFFFFFD.
- Same stimulus without `DIV_SIGNED_EN` → `result_o`=0x00000001_7FFFFFFC.
REQ-031 `opdata2_i`=0, `opdata1_i`=0x1234 → `ready_o`=1 after 2 edges, `result_o`=0.
- Drop `start_i` → next edge `ready_o`=0.
REQ-032 Start 0xFFFFFFFF/3, then:
- assert `annul_i` at `cnt`=10 → FSM `DivFree` next edge, `ready_o` never rises;
- immediate new start 9/3 → `result_o`=0x00000000_00000003.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF → `result_o`=0x00000000_80000000.
- Separately, drive `rst`=0 at `cnt`=20 of any division → all outputs 0 on that edge, FSM `DivFree`.
